// File: rtl/dmac_pkg.sv
// -----------------------------------------------------------------------------
// dmac_pkg -- shared definitions for the DMA controller register block.
//
// Holds the register word offsets, CFG/BCFG field positions, reset values and
// small pack/unpack helpers. Used by dmac_ctrl_regs, the dmac_master
// integration and benches, so the address map lives in exactly one place.
// -----------------------------------------------------------------------------
package dmac_pkg;

  // Word index decoded from HADDR[4:2]
  typedef enum logic [2:0] {
    REG_SADDR  = 3'd0,  // 0x00
    REG_DADDR  = 3'd1,  // 0x04
    REG_CFG    = 3'd2,  // 0x08
    REG_BCFG   = 3'd3,  // 0x0C
    REG_CTRL   = 3'd4,  // 0x10
    REG_STATUS = 3'd5,  // 0x14
    REG_IM     = 3'd6,  // 0x18
    REG_RSVD   = 3'd7   // 0x1C: reads 0, writes dropped
  } dmac_reg_e;

  // CFG field positions
  localparam int CFG_SSIZE_LSB  = 0;
  localparam int CFG_DSIZE_LSB  = 4;
  localparam int CFG_SINC_LSB   = 8;
  localparam int CFG_DINC_LSB   = 12;
  localparam int CFG_WFI_BIT    = 16;
  localparam int CFG_IRQSRC_LSB = 20;

  // BCFG field positions
  localparam int BCFG_BSIZE_LSB  = 0;
  localparam int BCFG_BCOUNT_LSB = 8;

  // Control / status bits
  localparam int CTRL_START_BIT = 0;
  localparam int STATUS_DONE_BIT = 0;
  localparam int IM_DONE_BIT     = 0;

  typedef struct packed {
    logic [2:0] irqsrc;
    logic       wfi;
    logic [2:0] dinc;
    logic [2:0] sinc;
    logic [2:0] dsize;
    logic [2:0] ssize;
  } cfg_t;

  typedef struct packed {
    logic [7:0] bcount;
    logic [7:0] bsize;
  } bcfg_t;

  // Reset values
  localparam logic [31:0] SADDR_RST = 32'h0;
  localparam logic [31:0] DADDR_RST = 32'h0;
  localparam cfg_t        CFG_RST   = '0;
  localparam bcfg_t       BCFG_RST  = '0;

  function automatic cfg_t cfg_unpack(input logic [31:0] w);
    cfg_t c;
    c.ssize  = w[CFG_SSIZE_LSB  +: 3];
    c.dsize  = w[CFG_DSIZE_LSB  +: 3];
    c.sinc   = w[CFG_SINC_LSB   +: 3];
    c.dinc   = w[CFG_DINC_LSB   +: 3];
    c.wfi    = w[CFG_WFI_BIT];
    c.irqsrc = w[CFG_IRQSRC_LSB +: 3];
    return c;
  endfunction

  function automatic logic [31:0] cfg_pack(input cfg_t c);
    logic [31:0] w;
    w = '0;
    w[CFG_SSIZE_LSB  +: 3] = c.ssize;
    w[CFG_DSIZE_LSB  +: 3] = c.dsize;
    w[CFG_SINC_LSB   +: 3] = c.sinc;
    w[CFG_DINC_LSB   +: 3] = c.dinc;
    w[CFG_WFI_BIT]         = c.wfi;
    w[CFG_IRQSRC_LSB +: 3] = c.irqsrc;
    return w;
  endfunction

endpackage

// File: rtl/dmac_ctrl_regs.sv
// -----------------------------------------------------------------------------
// dmac_ctrl_regs -- AHB-Lite slave register block for one DMA channel.
//
// Ports
//   HCLK, HRESETn          clock, async active-low reset
//   HSEL/HTRANS/HSIZE/
//   HWRITE/HREADY/HADDR    AHB-Lite address phase (only HADDR[4:2] decoded)
//   HWDATA / HRDATA        write / read data (data phase)
//   HREADYOUT              always 1, zero wait states
//   saddr, daddr           source / destination base address
//   ssize, dsize, sinc,
//   dinc, wfi, irqsrc      CFG fields
//   bsize, bcount          BCFG fields
//   start                  one-cycle channel start pulse
//   done, busy             channel complete pulse / active level
//   irq                    STATUS.DONE & IM.DONE
//
// Build option
//   DMAC_CFG_LOCK_EN  when defined, SADDR/DADDR/CFG/BCFG ignore writes while
//                     busy=1; STATUS and IM stay writable.
// -----------------------------------------------------------------------------
module dmac_ctrl_regs
  import dmac_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [31:0] saddr,
  output logic [31:0] daddr,
  output logic [2:0]  ssize,
  output logic [2:0]  dsize,
  output logic [2:0]  sinc,
  output logic [2:0]  dinc,
  output logic [2:0]  irqsrc,
  output logic [7:0]  bsize,
  output logic [7:0]  bcount,
  output logic        wfi,
  output logic        start,
  input  logic        done,
  input  logic        busy,
  output logic        irq
);

  // Address-phase latch
  logic      dph_valid;
  logic      dph_write;
  dmac_reg_e dph_reg;

  logic [31:0] saddr_q;
  logic [31:0] daddr_q;
  cfg_t        cfg_q;
  bcfg_t       bcfg_q;
  logic        im_q;
  logic        done_q;
  logic        start_q;

  logic        wr;
  logic        cfg_wr_ok;
  logic [31:0] rdata;

  // Word accesses only: size, byte lane and upper address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{HSIZE, HTRANS[0], HADDR[31:5], HADDR[1:0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_valid <= 1'b0;
      dph_write <= 1'b0;
      dph_reg   <= REG_SADDR;
    end else begin
      dph_valid <= HSEL & HTRANS[1] & HREADY;
      if (HSEL & HTRANS[1] & HREADY) begin
        dph_write <= HWRITE;
        dph_reg   <= dmac_reg_e'(HADDR[4:2]);
      end
    end
  end

  assign wr = dph_valid & dph_write;

`ifdef DMAC_CFG_LOCK_EN
  // Freeze channel setup while a transfer is running
  assign cfg_wr_ok = ~busy;
`else
  assign cfg_wr_ok = 1'b1;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      saddr_q <= SADDR_RST;
      daddr_q <= DADDR_RST;
      cfg_q   <= CFG_RST;
      bcfg_q  <= BCFG_RST;
      im_q    <= 1'b0;
    end else if (wr) begin
      case (dph_reg)
        REG_SADDR: if (cfg_wr_ok) saddr_q <= HWDATA;
        REG_DADDR: if (cfg_wr_ok) daddr_q <= HWDATA;
        REG_CFG:   if (cfg_wr_ok) cfg_q   <= cfg_unpack(HWDATA);
        REG_BCFG:  if (cfg_wr_ok) bcfg_q  <= bcfg_t'(HWDATA[15:0]);
        REG_IM:    im_q <= HWDATA[IM_DONE_BIT];
        default:   ;
      endcase
    end
  end

  // Start request is dropped, not queued, when the channel is already busy
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) start_q <= 1'b0;
    else          start_q <= wr & (dph_reg == REG_CTRL) & HWDATA[CTRL_START_BIT] & ~busy;
  end

  // DONE is sticky W1C; a new done pulse beats a coincident clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      done_q <= 1'b0;
    else if (done)
      done_q <= 1'b1;
    else if (wr && dph_reg == REG_STATUS && HWDATA[STATUS_DONE_BIT])
      done_q <= 1'b0;
  end

  // Read data straight from the registers so a write followed by a read of the
  // same word returns the new value
  always_comb begin
    rdata = '0;
    if (dph_valid && !dph_write) begin
      case (dph_reg)
        REG_SADDR:  rdata = saddr_q;
        REG_DADDR:  rdata = daddr_q;
        REG_CFG:    rdata = cfg_pack(cfg_q);
        REG_BCFG:   rdata = {16'h0, bcfg_q};
        REG_CTRL:   rdata = {31'h0, busy};
        REG_STATUS: rdata = {31'h0, done_q};
        REG_IM:     rdata = {31'h0, im_q};
        default:    rdata = '0;
      endcase
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;

  assign saddr  = saddr_q;
  assign daddr  = daddr_q;
  assign ssize  = cfg_q.ssize;
  assign dsize  = cfg_q.dsize;
  assign sinc   = cfg_q.sinc;
  assign dinc   = cfg_q.dinc;
  assign wfi    = cfg_q.wfi;
  assign irqsrc = cfg_q.irqsrc;
  assign bsize  = bcfg_q.bsize;
  assign bcount = bcfg_q.bcount;
  assign start  = start_q;
  assign irq    = done_q & im_q;

endmodule

// File: tb/tb_dmac_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_dmac_ctrl_regs -- self-checking bench for dmac_ctrl_regs.
// Reference model keeps the register file as an array of words with per-offset
// write masks and applies the register-map rules directly.
// -----------------------------------------------------------------------------
module tb_dmac_ctrl_regs;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [31:0] saddr, daddr;
  logic [2:0]  ssize, dsize, sinc, dinc, irqsrc;
  logic [7:0]  bsize, bcount;
  logic        wfi, start, done, busy, irq;

  dmac_ctrl_regs dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HREADY(HREADY), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .saddr(saddr), .daddr(daddr),
    .ssize(ssize), .dsize(dsize), .sinc(sinc), .dinc(dinc), .irqsrc(irqsrc),
    .bsize(bsize), .bcount(bcount), .wfi(wfi), .start(start), .done(done),
    .busy(busy), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

`ifdef DMAC_CFG_LOCK_EN
  bit lock = 1'b1;
`else
  bit lock = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_reg [0:7];
  bit          m_start;

  function automatic logic [31:0] wmask(input int off);
    case (off)
      0, 1:    return 32'hFFFF_FFFF;
      2:       return 32'h0071_7777;
      3:       return 32'h0000_FFFF;
      5, 6:    return 32'h0000_0001;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    m_start = 1'b0;
  endtask

  task automatic m_write(input int off, input logic [31:0] d, input bit dn);
    if (off <= 3) begin
      if (!(lock && busy)) m_reg[off] = d & wmask(off);
    end else if (off == 6) begin
      m_reg[6] = d & 32'h1;
    end else if (off == 5) begin
      if (d[0]) m_reg[5] = 32'h0;
    end
    if (dn) m_reg[5] = 32'h1;
    m_start = (off == 4) && d[0] && !busy;
  endtask

  function automatic logic [31:0] m_read(input int off);
    if (off == 4) return {31'h0, busy};
    return m_reg[off];
  endfunction

  task automatic check_outs();
    chk("saddr",  saddr,  m_reg[0]);
    chk("daddr",  daddr,  m_reg[1]);
    chk("ssize",  32'(ssize),  (m_reg[2] >> 0)  % 8);
    chk("dsize",  32'(dsize),  (m_reg[2] >> 4)  % 8);
    chk("sinc",   32'(sinc),   (m_reg[2] >> 8)  % 8);
    chk("dinc",   32'(dinc),   (m_reg[2] >> 12) % 8);
    chk("wfi",    32'(wfi),    (m_reg[2] >> 16) % 2);
    chk("irqsrc", 32'(irqsrc), (m_reg[2] >> 20) % 8);
    chk("bsize",  32'(bsize),  m_reg[3] % 256);
    chk("bcount", 32'(bcount), (m_reg[3] >> 8) % 256);
    chk("irq",    32'(irq),    m_reg[5] & m_reg[6]);
    chk("hready", 32'(HREADYOUT), 32'h1);
  endtask

  // ---------------- bus tasks (enter/leave at posedge+1) ----------------
  function automatic logic [31:0] mk_addr(input int off);
    logic [31:0] a;
    a = $urandom();
    a[4:2] = 3'(off);
    a[1:0] = 2'b00;
    return a;
  endfunction

  // Single transfer: address phase, data phase, then one idle cycle to observe start
  task automatic xfer(input bit wr, input int off, input logic [31:0] wd, input bit dn);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = mk_addr(off);
    HSIZE = 3'($urandom_range(0, 2));
    @(negedge HCLK);
    chk("start_idle", 32'(start), 32'h0);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd; done = dn;
    @(negedge HCLK);
    if (!wr) chk($sformatf("rd%0d", off), HRDATA, m_read(off));
    @(posedge HCLK); #1;
    done = 1'b0;
    if (wr) m_write(off, wd, dn);
    else begin
      m_start = 1'b0;
      if (dn) m_reg[5] = 32'h1;
    end
    @(negedge HCLK);
    chk("start", 32'(start), 32'(m_start));
    check_outs();
    m_start = 1'b0;
    @(posedge HCLK); #1;
  endtask

  // Write immediately followed by a pipelined read of the same word
  task automatic wr_rd(input int off, input logic [31:0] wd);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = mk_addr(off);
    @(posedge HCLK); #1;
    HWDATA = wd; HWRITE = 1'b0; HADDR = mk_addr(off);
    m_write(off, wd, 1'b0);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    chk($sformatf("b2b%0d", off), HRDATA, m_read(off));
    chk("b2b_start", 32'(start), 32'(m_start));
    m_start = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic done_pulse();
    done = 1'b1;
    @(posedge HCLK); #1;
    done = 1'b0;
    m_reg[5] = 32'h1;
    @(negedge HCLK);
    check_outs();
    @(posedge HCLK); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, off;
    logic [31:0] d;
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HSIZE = 3'd2; HWRITE = 1'b0;
    HREADY = 1'b1; HADDR = '0; HWDATA = '0; done = 1'b0; busy = 1'b0;
    m_clear();
    #23;
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    check_outs();
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Configuration write / readback
    xfer(1, 0, 32'h2000_0000, 0);
    xfer(1, 1, 32'h2000_1000, 0);
    xfer(1, 2, 32'h0011_1222, 0);
    xfer(1, 3, 32'h0000_0304, 0);
    chk("ssize_k", 32'(ssize), 32'd2);
    chk("dinc_k",  32'(dinc),  32'd1);
    chk("wfi_k",   32'(wfi),   32'd1);
    chk("bcount_k", 32'(bcount), 32'd3);
    for (int i = 0; i < 4; i++) xfer(0, i, 32'h0, 0);

    // Start pulse with and without busy
    xfer(1, 4, 32'h1, 0);
    busy = 1'b1;
    xfer(1, 4, 32'h1, 0);
    xfer(0, 4, 32'h0, 0);
    busy = 1'b0;

    // Done / irq / W1C
    xfer(1, 6, 32'h1, 0);
    done_pulse();
    xfer(0, 5, 32'h0, 0);
    chk("irq_set", 32'(irq), 32'h1);
    xfer(1, 5, 32'h1, 0);
    chk("irq_clr", 32'(irq), 32'h0);
    xfer(1, 5, 32'h1, 1);
    chk("done_wins", 32'(irq), 32'h1);

    // Lock behaviour
    busy = 1'b1;
    xfer(1, 0, 32'hDEAD_BEEF, 0);
    chk("lock_saddr", saddr, lock ? 32'h2000_0000 : 32'hDEAD_BEEF);
    busy = 1'b0;

    // Reserved offset and back-to-back
    xfer(1, 7, 32'hFFFF_FFFF, 0);
    xfer(0, 7, 32'h0, 0);
    wr_rd(1, 32'h1234_5678);
    wr_rd(2, 32'hFFFF_FFFF);
    wr_rd(6, 32'h0);

    // Reset in the middle of a DADDR write data phase
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = mk_addr(1);
    @(posedge HCLK); #1;
    HWDATA = 32'hCAFE_F00D; HSEL = 1'b0; HTRANS = 2'b00;
    #1 HRESETn = 1'b0;
    #1;
    m_clear();
    chk("midrst_hready", 32'(HREADYOUT), 32'h1);
    chk("midrst_daddr", daddr, 32'h0);
    chk("midrst_hrdata", HRDATA, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    check_outs();
    @(posedge HCLK); #1;

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      busy = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      off  = $urandom_range(0, 7);
      d    = $urandom();
      if (r <= 5)      xfer(1, off, d, ($urandom_range(0, 7) == 0));
      else if (r <= 7) xfer(0, off, 32'h0, 0);
      else if (r == 8) wr_rd(off, d);
      else             done_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
